usart_tx_gen: RTL
=================

# usart_tx_gen

Parametrised USART transmit serializer for the Sigma Delta DAQ link. It serializes one word per frame: start bit, data LSB-first, an optional CRC computed inline, optional parity, then one or two stop bits. A programmable clocks-per-bit divider sets the bit rate. It replaces the fixed one-bit-per-clock, CRC-8-only transmitter and feeds the board-level TX pin from the acquisition packetiser.

## Interface
- DATA_WIDTH, 8: payload bits per frame (1..32).
- CRC_EN, 1: 1 appends a CRC field after data; 0 omits it.
- CRC_WIDTH, 8: CRC field width (1..16); ignored when CRC_EN=0.
- CRC_POLY, 'h07: generator polynomial without the implicit top bit; CRC_WIDTH bits.
- PARITY_MODE, 1: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- CLKS_PER_BIT, 1: clock cycles per serial bit (≥1).
- clk  in  1  system clock; all logic is on the rising edge.
- rsnt  in  1  reset; asynchronous, active-low.
- data  in  DATA_WIDTH  word to send; sampled only on acceptance.
- valid  in  1  data is valid.
- ready  out  1  block can accept a word.
- sig  out  1  serial line; idle high.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- FRAME_BITS = 1 + DATA_WIDTH + CRC_EN·CRC_WIDTH + (PARITY_MODE≠0) + STOP_BITS. The default frame is 19 bits.
- FSM states: IDLE, START, DATA, CRC, PARITY, STOP.
  - Each non-IDLE state holds its bit for CLKS_PER_BIT cycles, counted by a baud counter that runs 0..CLKS_PER_BIT-1.
  - A bit index counter steps through DATA, CRC and STOP bits.
- IDLE → START on valid && ready. On acceptance:
  - data is latched into the shift register.
  - The CRC register clears to 0.
  - The parity accumulator loads 0 for even mode and 1 for odd mode.
- START (sig=0) → DATA.
- DATA sends data[0] first.
  - On each data bit, the CRC updates: fb = crc[CRC_WIDTH-1] ^ bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0). Result width is CRC_WIDTH; the MSB is discarded.
  - Parity accumulates by XOR.
  - After the last data bit: → CRC if CRC_EN, else → PARITY if PARITY_MODE≠0, else → STOP.
- CRC sends the final CRC value LSB-first (crc[0] first). The CRC register is frozen during this state. CRC bits are included in the parity accumulation. Exit → PARITY or STOP.
- PARITY sends the accumulator.
  - Even mode: the total count of ones over data, CRC and parity is even.
  - Odd mode: that count is odd.
- STOP sends sig=1 for STOP_BITS bit periods, then → IDLE with a done pulse.
- Changes to data or valid after acceptance are ignored. A valid received while busy is not accepted and is not queued.
- CRC_EN=0 with PARITY_MODE=0 yields a plain 8N1-style frame.

## Timing
- Reset values: sig=1, ready=1, busy=0, done=0, state=IDLE. All counters and registers are 0.
- Reset is asynchronous: asserting rsnt mid-frame forces sig=1 and ready=1 immediately and aborts the frame. No partial frame resumes after release.
- Acceptance at rising edge E (valid && ready sampled high):
  - ready=0 and busy=1 from E onward.
  - The start bit appears on sig from E for CLKS_PER_BIT cycles.
  - Bit k occupies cycles [E + k·CLKS_PER_BIT, E + (k+1)·CLKS_PER_BIT).
- Final stop bit end:
  - done=1 for exactly one cycle, during the cycle after the final stop bit period, i.e. at E + FRAME_BITS·CLKS_PER_BIT.
  - ready=1 and busy=0 in that same cycle.
  - sig stays 1, so there is at least one idle clock between frames.
- Back-to-back: valid held high re-accepts at the edge ending the done cycle. The next start bit follows immediately, giving a frame period of FRAME_BITS·CLKS_PER_BIT + 1 cycles.
- valid while ready=0 has no effect. ready never depends combinationally on valid.
- CLKS_PER_BIT=1: the baud counter is a constant 0 and each state lasts one cycle.

## Test plan
- CRC_EN=0, PARITY_MODE=1, STOP_BITS=1, CPB=1, data=0xA5 → sig = 0,1,0,1,0,0,1,0,1,0,1 (start, data, parity 0, stop); done pulses 11 cycles after acceptance.
- Defaults with CPB=4, data=0x80 → CRC=0x07 sent as 1,1,1,0,0,0,0,0; parity 0; each bit lasts 4 clocks; 76 cycles to done.
- As above with PARITY_MODE=2 → parity bit 1; data=0x00 gives CRC 0x00 and parity 1.
- Back-to-back: valid held high with 0x12 then 0x34 (CRC_EN=0, PARITY_MODE=0, STOP_BITS=2, CPB=1) → two 11-bit frames with exactly one idle clock between them; data changes mid-frame are ignored.
- rsnt pulled low mid-CRC field → sig=1 and ready=1 asynchronously; after release, a new 0x55 frame is correct from its start bit.
- valid pulsed while busy → no acceptance, ready stays 0, and the frame in progress is unaltered.

Source files
------------

// File: rtl/usart_tx_gen.sv
// USART transmit serializer: start, LSB-first data, optional inline CRC, optional parity, stop bits.
// A clocks-per-bit divider sets the bit rate; done pulses in the idle cycle that follows a frame.
module usart_tx_gen #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           CRC_EN       = 1,
  parameter int unsigned           CRC_WIDTH    = 8,
  parameter logic [CRC_WIDTH-1:0]  CRC_POLY     = 'h07,
  parameter int unsigned           PARITY_MODE  = 1,
  parameter int unsigned           STOP_BITS    = 1,
  parameter int unsigned           CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rsnt,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  sig,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SW = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = 6;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] CRC_LAST  = IW'(CRC_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StCrc, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d;
  logic                   par_q, par_d;
  logic                   done_q, done_d;

  logic                   bit_end;
  logic                   crc_fb;
  logic [CRC_WIDTH-1:0]   crc_upd;
  state_e                 after_data, after_crc;

  assign bit_end    = (baud_q == BAUD_LAST);
  assign crc_fb     = crc_q[CRC_WIDTH-1] ^ shift_q[0];
  assign crc_upd    = (crc_q << 1) ^ (crc_fb ? CRC_POLY : '0);
  assign after_crc  = (PARITY_MODE != 0) ? StParity : StStop;
  assign after_data = (CRC_EN != 0) ? StCrc : after_crc;

  always_ff @(posedge clk or negedge rsnt) begin
    if (!rsnt) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      crc_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (valid) state_d = StStart;
      StStart:  if (bit_end) state_d = StData;
      StData:   if (bit_end && idx_q == DATA_LAST) state_d = after_data;
      StCrc:    if (bit_end && idx_q == CRC_LAST) state_d = after_crc;
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end && idx_q == STOP_LAST) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: baud/bit counters, shift register, CRC and parity accumulators.
  always_comb begin
    baud_d  = (state_q == StIdle || bit_end) ? '0 : baud_q + BW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    par_d   = par_q;
    done_d  = (state_q == StStop) && bit_end && (idx_q == STOP_LAST);

    if (state_q != StIdle && bit_end) begin
      idx_d = (state_d != state_q) ? '0 : idx_q + IW'(1);
    end

    if (state_q == StIdle && valid) begin
      shift_d = SW'(data);
      crc_d   = '0;
      par_d   = (PARITY_MODE == 2);
    end else if (state_q == StData && bit_end) begin
      crc_d   = crc_upd;
      par_d   = par_q ^ shift_q[0];
      // The finished CRC replaces the spent data so both fields shift out of bit 0.
      if (idx_q == DATA_LAST && CRC_EN != 0) shift_d = SW'(crc_upd);
      else                                   shift_d = shift_q >> 1;
    end else if (state_q == StCrc && bit_end) begin
      par_d   = par_q ^ shift_q[0];
      shift_d = shift_q >> 1;
    end
  end

  always_comb begin
    sig   = 1'b1;
    ready = (state_q == StIdle);
    busy  = (state_q != StIdle);
    done  = done_q;
    unique case (state_q)
      StStart:       sig = 1'b0;
      StData, StCrc: sig = shift_q[0];
      StParity:      sig = par_q;
      default:       sig = 1'b1;
    endcase
  end

endmodule
